// File: rtl/alu_seq_if.sv
// Op/result bus between decode, the sequential ALU and register-file writeback.
interface alu_seq_if #(
    parameter int unsigned WORD_SIZE = 8
) ();
    logic                 in_valid;
    logic                 in_ready;
    logic [3:0]           op;
    logic [WORD_SIZE-1:0] input_A;
    logic [WORD_SIZE-1:0] input_B;
    logic                 out_valid;
    logic [WORD_SIZE-1:0] output_C;
    logic [WORD_SIZE-1:0] output_hi;
    logic [7:0]           flags;

    modport master (
        output in_valid, op, input_A, input_B,
        input  in_ready, out_valid, output_C, output_hi, flags
    );

    modport slave (
        input  in_valid, op, input_A, input_B,
        output in_ready, out_valid, output_C, output_hi, flags
    );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with internal Z/S/C/O flag register and multi-cycle shift-add MUL.
module alu_seq #(
    parameter int unsigned WORD_SIZE = 8
) (
    input logic     clk,
    input logic     rst_n,
    alu_seq_if.slave bus
);
    localparam int unsigned W  = WORD_SIZE;
    localparam int unsigned CW = $clog2(W + 1);

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_MOV   = 4'd1;
    localparam logic [3:0] OP_CMP   = 4'd2;
    localparam logic [3:0] OP_TEST  = 4'd3;
    localparam logic [3:0] OP_SHL   = 4'd4;
    localparam logic [3:0] OP_SHR   = 4'd5;
    localparam logic [3:0] OP_ADD   = 4'd6;
    localparam logic [3:0] OP_ADC   = 4'd7;
    localparam logic [3:0] OP_SUB   = 4'd8;
    localparam logic [3:0] OP_SBB   = 4'd9;
    localparam logic [3:0] OP_MUL   = 4'd10;
    localparam logic [3:0] OP_AND   = 4'd11;
    localparam logic [3:0] OP_OR    = 4'd12;
    localparam logic [3:0] OP_XOR   = 4'd13;
    localparam logic [3:0] OP_NOT   = 4'd14;
    localparam logic [3:0] OP_CLRF  = 4'd15;

    typedef enum logic {IDLE, MUL_RUN} state_t;

    state_t          state_q, state_n;
    logic [W-1:0]    c_q, c_n;
    logic [W-1:0]    hi_q, hi_n;
    logic [3:0]      fl_q, fl_n;     // {Z, S, C, O}
    logic            ov_q, ov_n;
    logic [2*W-1:0]  ma_q, ma_n;
    logic [W-1:0]    mb_q, mb_n;
    logic [2*W-1:0]  acc_q, acc_n;
    logic [CW-1:0]   cnt_q, cnt_n;

    logic            accept;
    logic            cin;
    logic [W:0]      add_r;
    logic [W:0]      sub_r;
    logic [W:0]      shl_r;
    logic [W:0]      shr_r;
    logic            shamt_big;
    logic [W-1:0]    res;
    logic            hi_nz;

    function automatic logic [1:0] zs(input logic [W-1:0] v);
        return {v == '0, v[W-1]};
    endfunction

    assign bus.in_ready  = (state_q == IDLE) && rst_n;
    assign bus.out_valid = ov_q;
    assign bus.output_C  = c_q;
    assign bus.output_hi = hi_q;
    assign bus.flags     = {fl_q, 4'b0000};

    assign accept    = bus.in_valid && bus.in_ready;
    // Carry/borrow-in is the flag register as it stands at the accepting edge.
    assign cin       = ((bus.op == OP_ADC) || (bus.op == OP_SBB)) ? fl_q[1] : 1'b0;
    assign add_r     = {1'b0, bus.input_A} + {1'b0, bus.input_B} + (W+1)'(cin);
    assign sub_r     = {1'b0, bus.input_A} - {1'b0, bus.input_B} - (W+1)'(cin);
    assign shl_r     = {1'b0, bus.input_A} << bus.input_B;
    assign shr_r     = {bus.input_A, 1'b0} >> bus.input_B;
    assign shamt_big = bus.input_B > W'(W);

    // Next-state, datapath and output logic.
    always_comb begin
        state_n = state_q;
        c_n     = c_q;
        hi_n    = hi_q;
        fl_n    = fl_q;
        ov_n    = 1'b0;
        ma_n    = ma_q;
        mb_n    = mb_q;
        acc_n   = acc_q;
        cnt_n   = cnt_q;
        res     = '0;
        hi_nz   = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    ov_n = (bus.op != OP_MUL);
                    case (bus.op)
                        OP_NOP: ;
                        OP_MOV: begin
                            c_n  = bus.input_B;
                            hi_n = '0;
                        end
                        OP_CMP: begin
                            res  = sub_r[W-1:0];
                            fl_n = {zs(res), sub_r[W],
                                    (bus.input_A[W-1] != bus.input_B[W-1]) && (res[W-1] != bus.input_A[W-1])};
                        end
                        OP_TEST: begin
                            res  = bus.input_A & bus.input_B;
                            fl_n = {zs(res), 2'b00};
                        end
                        OP_SHL, OP_SHR: begin
                            hi_n = '0;
                            if (bus.input_B == '0) begin
                                c_n = bus.input_A;
                            end else if (shamt_big) begin
                                c_n  = '0;
                                fl_n = 4'b1000;
                            end else if (bus.op == OP_SHL) begin
                                c_n  = shl_r[W-1:0];
                                fl_n = {zs(c_n), shl_r[W], 1'b0};
                            end else begin
                                c_n  = shr_r[W:1];
                                fl_n = {zs(c_n), shr_r[0], 1'b0};
                            end
                        end
                        OP_ADD, OP_ADC: begin
                            c_n  = add_r[W-1:0];
                            hi_n = '0;
                            fl_n = {zs(c_n), add_r[W],
                                    (bus.input_A[W-1] == bus.input_B[W-1]) && (c_n[W-1] != bus.input_A[W-1])};
                        end
                        OP_SUB, OP_SBB: begin
                            c_n  = sub_r[W-1:0];
                            hi_n = '0;
                            fl_n = {zs(c_n), sub_r[W],
                                    (bus.input_A[W-1] != bus.input_B[W-1]) && (c_n[W-1] != bus.input_A[W-1])};
                        end
                        OP_MUL: begin
                            ma_n    = {W'(0), bus.input_A};
                            mb_n    = bus.input_B;
                            acc_n   = '0;
                            cnt_n   = '0;
                            state_n = MUL_RUN;
                        end
                        OP_AND, OP_OR, OP_XOR: begin
                            if (bus.op == OP_AND)     c_n = bus.input_A & bus.input_B;
                            else if (bus.op == OP_OR) c_n = bus.input_A | bus.input_B;
                            else                      c_n = bus.input_A ^ bus.input_B;
                            hi_n = '0;
                            fl_n = {zs(c_n), 2'b00};
                        end
                        OP_NOT: begin
                            c_n  = ~bus.input_A;
                            hi_n = '0;
                        end
                        OP_CLRF: fl_n = 4'b0000;
                        default: ;
                    endcase
                end
            end
            MUL_RUN: begin
                // One shift-add step per cycle; the final step publishes the product.
                acc_n = acc_q + (mb_q[0] ? ma_q : '0);
                ma_n  = ma_q << 1;
                mb_n  = mb_q >> 1;
                cnt_n = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    hi_nz   = acc_n[2*W-1:W] != '0;
                    c_n     = acc_n[W-1:0];
                    hi_n    = acc_n[2*W-1:W];
                    fl_n    = {acc_n == '0, acc_n[W-1], hi_nz, hi_nz};
                    ov_n    = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            c_q     <= '0;
            hi_q    <= '0;
            fl_q    <= '0;
            ov_q    <= 1'b0;
            ma_q    <= '0;
            mb_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_n;
            c_q     <= c_n;
            hi_q    <= hi_n;
            fl_q    <= fl_n;
            ov_q    <= ov_n;
            ma_q    <= ma_n;
            mb_q    <= mb_n;
            acc_q   <= acc_n;
            cnt_q   <= cnt_n;
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WORD_SIZE=8 and WORD_SIZE=16.
module tb_alu_seq;
    localparam logic [3:0] NOP = 4'd0, MOV = 4'd1, CMP = 4'd2, TEST = 4'd3;
    localparam logic [3:0] SHL = 4'd4, SHR = 4'd5, ADD = 4'd6, ADC = 4'd7;
    localparam logic [3:0] SUB = 4'd8, SBB = 4'd9, MUL = 4'd10, AND = 4'd11;
    localparam logic [3:0] OR = 4'd12, XOR = 4'd13, NOT = 4'd14, CLRF = 4'd15;

    typedef struct packed {
        logic [3:0]  op;
        logic [15:0] a, b, c, hi;
        logic [7:0]  f;
    } vec_t;

    typedef struct packed {
        logic [15:0] c, hi;
        logic [7:0]  f;
        logic [15:0] idx;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n8, rst_n16;
    always #5 clk = ~clk;

    alu_seq_if #(.WORD_SIZE(8))  bus8  ();
    alu_seq_if #(.WORD_SIZE(16)) bus16 ();

    alu_seq #(.WORD_SIZE(8))  dut8  (.clk(clk), .rst_n(rst_n8),  .bus(bus8));
    alu_seq #(.WORD_SIZE(16)) dut16 (.clk(clk), .rst_n(rst_n16), .bus(bus16));

    int   tests = 0;
    int   fails = 0;
    exp_t q8[$];
    exp_t q16[$];
    exp_t e8, e16;
    int   ov_run8 = 0, ov_max8 = 0;

    vec_t tbl8[25];
    vec_t tbl16[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Scoreboard: pop and compare on every result pulse.
    always @(negedge clk) begin
        if (bus8.out_valid === 1'b1) begin
            ov_run8 = ov_run8 + 1;
            if (ov_run8 > ov_max8) ov_max8 = ov_run8;
            if (q8.size() == 0) begin
                tests++; fails++;
                $display("FAIL w8 unexpected out_valid");
            end else begin
                e8 = q8.pop_front();
                check($sformatf("w8 #%0d C", e8.idx),     32'(bus8.output_C),  32'(e8.c[7:0]));
                check($sformatf("w8 #%0d hi", e8.idx),    32'(bus8.output_hi), 32'(e8.hi[7:0]));
                check($sformatf("w8 #%0d flags", e8.idx), 32'(bus8.flags),     32'(e8.f));
            end
        end else begin
            ov_run8 = 0;
        end
        if (bus16.out_valid === 1'b1) begin
            if (q16.size() == 0) begin
                tests++; fails++;
                $display("FAIL w16 unexpected out_valid");
            end else begin
                e16 = q16.pop_front();
                check($sformatf("w16 #%0d C", e16.idx),     32'(bus16.output_C),  32'(e16.c));
                check($sformatf("w16 #%0d hi", e16.idx),    32'(bus16.output_hi), 32'(e16.hi));
                check($sformatf("w16 #%0d flags", e16.idx), 32'(bus16.flags),     32'(e16.f));
            end
        end
    end

    // Present one op from the negedge until accepted; leaves in_valid asserted.
    task automatic drive8(input vec_t v, input logic [15:0] idx, input bit push);
        int guard = 0;
        @(negedge clk);
        while (bus8.in_ready !== 1'b1 && guard < 100) begin
            guard++;
            @(negedge clk);
        end
        if (guard >= 100) begin
            tests++; fails++;
            $display("FAIL w8 #%0d in_ready timeout", idx);
        end
        bus8.in_valid = 1'b1;
        bus8.op       = v.op;
        bus8.input_A  = v.a[7:0];
        bus8.input_B  = v.b[7:0];
        if (push) q8.push_back('{c: v.c, hi: v.hi, f: v.f, idx: idx});
        @(posedge clk);
    endtask

    task automatic drive16(input vec_t v, input logic [15:0] idx);
        int guard = 0;
        @(negedge clk);
        while (bus16.in_ready !== 1'b1 && guard < 100) begin
            guard++;
            @(negedge clk);
        end
        if (guard >= 100) begin
            tests++; fails++;
            $display("FAIL w16 #%0d in_ready timeout", idx);
        end
        bus16.in_valid = 1'b1;
        bus16.op       = v.op;
        bus16.input_A  = v.a;
        bus16.input_B  = v.b;
        q16.push_back('{c: v.c, hi: v.hi, f: v.f, idx: idx});
        @(posedge clk);
    endtask

    task automatic drain(input string name);
        int guard = 0;
        while ((q8.size() != 0 || q16.size() != 0) && guard < 100) begin
            guard++;
            @(negedge clk);
        end
        tests++;
        if (q8.size() != 0 || q16.size() != 0) begin
            fails++;
            $display("FAIL %s drain: %0d/%0d results missing, expected 0", name, q8.size(), q16.size());
        end
    endtask

    // Measure in_ready-low cycles and edges from accept to result for a MUL just accepted.
    task automatic mul_timing8(input int w);
        int low = 0;
        int lat = -1;
        for (int k = 1; k <= 3 * w; k++) begin
            @(negedge clk);
            if (bus8.in_ready !== 1'b1) low++;
            else bus8.in_valid = 1'b0;
            if (bus8.out_valid === 1'b1 && lat < 0) lat = k - 1;
        end
        check("w8 mul in_ready low cycles", 32'(low), 32'(w));
        check("w8 mul edges accept->result", 32'(lat), 32'(w));
    endtask

    initial begin
        tbl8[0]  = '{ADD,  16'hff, 16'h01, 16'h00, 16'h00, 8'hA0};
        tbl8[1]  = '{ADC,  16'h01, 16'h00, 16'h02, 16'h00, 8'h00};
        tbl8[2]  = '{MUL,  16'hc8, 16'h03, 16'h58, 16'h02, 8'h30};
        tbl8[3]  = '{MUL,  16'h0f, 16'h11, 16'hff, 16'h00, 8'h40};
        tbl8[4]  = '{MUL,  16'h00, 16'h63, 16'h00, 16'h00, 8'h80};
        tbl8[5]  = '{SHL,  16'h80, 16'h01, 16'h00, 16'h00, 8'hA0};
        tbl8[6]  = '{SHR,  16'h01, 16'h01, 16'h00, 16'h00, 8'hA0};
        tbl8[7]  = '{SHR,  16'hff, 16'h00, 16'hff, 16'h00, 8'hA0};
        tbl8[8]  = '{SHL,  16'h01, 16'h09, 16'h00, 16'h00, 8'h80};
        tbl8[9]  = '{SHR,  16'h80, 16'h08, 16'h00, 16'h00, 8'hA0};
        tbl8[10] = '{SHL,  16'h81, 16'h08, 16'h00, 16'h00, 8'hA0};
        tbl8[11] = '{SHL,  16'h21, 16'h02, 16'h84, 16'h00, 8'h40};
        tbl8[12] = '{CLRF, 16'h00, 16'h00, 16'h84, 16'h00, 8'h00};
        tbl8[13] = '{MOV,  16'h00, 16'h4d, 16'h4d, 16'h00, 8'h00};
        tbl8[14] = '{TEST, 16'h83, 16'h88, 16'h4d, 16'h00, 8'h40};
        tbl8[15] = '{NOT,  16'h0f, 16'h00, 16'hf0, 16'h00, 8'h40};
        tbl8[16] = '{NOP,  16'h12, 16'h34, 16'hf0, 16'h00, 8'h40};
        tbl8[17] = '{XOR,  16'hf0, 16'hf0, 16'h00, 16'h00, 8'h80};
        tbl8[18] = '{SUB,  16'h00, 16'h01, 16'hff, 16'h00, 8'h60};
        tbl8[19] = '{SBB,  16'h05, 16'h02, 16'h02, 16'h00, 8'h00};
        tbl8[20] = '{OR,   16'h80, 16'h01, 16'h81, 16'h00, 8'h40};
        tbl8[21] = '{MUL,  16'hc8, 16'h03, 16'h58, 16'h02, 8'h30};
        tbl8[22] = '{CMP,  16'h01, 16'h02, 16'h58, 16'h02, 8'h60};
        tbl8[23] = '{AND,  16'hff, 16'h0f, 16'h0f, 16'h00, 8'h00};
        tbl8[24] = '{SUB,  16'h80, 16'h01, 16'h7f, 16'h00, 8'h10};

        tbl16[0] = '{MUL,  16'hffff, 16'hffff, 16'h0001, 16'hfffe, 8'h30};
        tbl16[1] = '{MUL,  16'h00c8, 16'h0003, 16'h0258, 16'h0000, 8'h00};
        tbl16[2] = '{ADD,  16'hffff, 16'h0001, 16'h0000, 16'h0000, 8'hA0};

        rst_n8 = 1'b0; rst_n16 = 1'b0;
        bus8.in_valid = 1'b0;  bus8.op = NOP;  bus8.input_A = '0;  bus8.input_B = '0;
        bus16.in_valid = 1'b0; bus16.op = NOP; bus16.input_A = '0; bus16.input_B = '0;
        repeat (2) @(negedge clk);
        check("reset in_ready", 32'(bus8.in_ready), 32'd0);
        rst_n8 = 1'b1; rst_n16 = 1'b1;
        @(negedge clk);
        check("reset C",         32'(bus8.output_C),  32'd0);
        check("reset hi",        32'(bus8.output_hi), 32'd0);
        check("reset flags",     32'(bus8.flags),     32'd0);
        check("reset out_valid", 32'(bus8.out_valid), 32'd0);
        check("idle in_ready",   32'(bus8.in_ready),  32'd1);

        for (int i = 0; i < 25; i++) drive8(tbl8[i], 16'(i), 1'b1);
        @(negedge clk) bus8.in_valid = 1'b0;
        drain("table8");

        // Back-to-back single-cycle ops give an unbroken result burst.
        @(posedge clk);
        ov_max8 = 0;
        drive8('{ADD, 16'h7f, 16'h01, 16'h80, 16'h00, 8'h50}, 16'd100, 1'b1);
        drive8('{SUB, 16'h28, 16'h32, 16'hf6, 16'h00, 8'h60}, 16'd101, 1'b1);
        drive8('{CMP, 16'h05, 16'h05, 16'hf6, 16'h00, 8'h80}, 16'd102, 1'b1);
        @(negedge clk) bus8.in_valid = 1'b0;
        drain("burst");
        check("burst out_valid run", 32'(ov_max8), 32'd3);

        // MUL timing with in_valid held high throughout MUL_RUN.
        drive8('{MUL, 16'hc8, 16'h03, 16'h58, 16'h02, 8'h30}, 16'd200, 1'b1);
        mul_timing8(8);
        drain("mul timing");

        // Reset in the middle of a MUL aborts it without a result.
        drive8('{MUL, 16'h0f, 16'h11, 16'h00, 16'h00, 8'h00}, 16'd300, 1'b0);
        @(negedge clk) bus8.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n8 = 1'b0;
        #1;
        check("abort C",         32'(bus8.output_C),  32'd0);
        check("abort hi",        32'(bus8.output_hi), 32'd0);
        check("abort flags",     32'(bus8.flags),     32'd0);
        check("abort out_valid", 32'(bus8.out_valid), 32'd0);
        check("abort in_ready",  32'(bus8.in_ready),  32'd0);
        repeat (2) @(negedge clk);
        rst_n8 = 1'b1;
        @(negedge clk);
        check("post-abort in_ready", 32'(bus8.in_ready), 32'd1);
        drive8('{ADD, 16'h0a, 16'h1e, 16'h28, 16'h00, 8'h00}, 16'd301, 1'b1);
        @(negedge clk) bus8.in_valid = 1'b0;
        repeat (20) @(negedge clk);
        drain("abort");

        for (int i = 0; i < 3; i++) drive16(tbl16[i], 16'(400 + i));
        @(negedge clk) bus16.in_valid = 1'b0;
        drain("table16");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
